// File: rtl/mem_bytebus_pkg.sv
// Shared types and helpers for the byte-addressed memory.
// Lane k of a big-endian word is byte addr+k and lives in
// data bits [8*(nb-1-k) +: 8] and mask bit nb-1-k.
package mem_bytebus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BEAT2,
    RESP
  } state_t;

  // Upper bound on bytes per word handled by the rotate helpers.
  localparam int MAX_NB = 16;
  localparam int MAX_W  = 8 * MAX_NB;

  function automatic int calc_nb(input int data_w);
    return data_w / 8;
  endfunction

  // Output position p takes input lane (p - off) mod nb.
  function automatic logic [MAX_NB-1:0] rot_mask(input logic [MAX_NB-1:0] mask,
                                                 input int nb, input int off);
    logic [MAX_NB-1:0] r;
    r = '0;
    for (int p = 0; p < MAX_NB; p++) begin
      if (p < nb) r[nb-1-p] = mask[nb-1-((p - off + nb) % nb)];
    end
    return r;
  endfunction

  // Same lane rotation applied to byte data.
  function automatic logic [MAX_W-1:0] rot_data(input logic [MAX_W-1:0] data,
                                                input int nb, input int off);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int p = 0; p < MAX_NB; p++) begin
      if (p < nb) r[8*(nb-1-p) +: 8] = data[8*(nb-1-((p - off + nb) % nb)) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte storage organised as NB byte lanes sharing one word index.
// Port p (mask bit NB-1-p, data byte NB-1-p) addresses byte word*NB+p.
// Each port has its own write enable and a registered read.
module mem_byte_array #(
  parameter int    NB          = 2,
  parameter int    DEPTH_BYTES = 64,
  parameter int    WI_W        = 5,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WI_W-1:0]   word,
  input  logic [NB-1:0]     en,
  input  logic [NB-1:0]     we,
  input  logic [8*NB-1:0]   wdata,
  output logic [8*NB-1:0]   rdata
);

  localparam int BA_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  logic [7:0] mem [DEPTH_BYTES];

  function automatic logic [BA_W-1:0] byte_addr(input logic [WI_W-1:0] w, input int p);
    return BA_W'(int'(w) * NB + p);
  endfunction

  // Per-lane byte writes.
  // NOTE: storage has no reset branch; clearing a RAM array is not
  // implementable in block memory, so its contents start undefined.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NB; p++) begin
      if (we[NB-1-p]) mem[byte_addr(word, p)] <= wdata[8*(NB-1-p) +: 8];
    end
  end

  // Per-lane registered read; holds when the lane is not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      for (int p = 0; p < NB; p++) begin
        if (en[NB-1-p]) rdata[8*(NB-1-p) +: 8] <= mem[byte_addr(word, p)];
      end
    end
  end

endmodule

// File: rtl/mem_bytebus.sv
// Byte-addressed data memory with valid/ready request and response
// channels, per-byte enables, big-endian words and two-beat handling
// of accesses that straddle a word boundary.
module mem_bytebus
  import mem_bytebus_pkg::*;
#(
  parameter int    DATA_W      = 16,
  parameter int    DEPTH_BYTES = 64,
  parameter int    ADDR_W      = 16,
  parameter string INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB          = calc_nb(DATA_W);
  localparam int DEPTH_WORDS = DEPTH_BYTES / NB;
  localparam int WI_W        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int OFF_W       = (NB > 1) ? $clog2(NB) : 1;

  state_t state, nxt;

  // Request decode in the accept cycle.
  logic [WI_W-1:0]   word_in;
  logic [OFF_W-1:0]  off_in;
  logic [ADDR_W:0]   last_byte;
  logic              err_in;

  // Request held for beat 2 and the response.
  logic              we_q;
  logic              err_q;
  logic [WI_W-1:0]   word_q;
  logic [OFF_W-1:0]  off_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;

  // Storage port drive.
  logic [WI_W-1:0]   arr_word;
  logic [NB-1:0]     arr_en;
  logic [NB-1:0]     arr_we;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] rd_lanes;

  // One extra address bit so the last byte of the access cannot wrap.
  assign last_byte = {1'b0, req_addr} + (ADDR_W+1)'(NB - 1);
  assign err_in    = (last_byte >= (ADDR_W+1)'(DEPTH_BYTES));
  assign word_in   = WI_W'(req_addr / ADDR_W'(NB));
  assign off_in    = OFF_W'(req_addr % ADDR_W'(NB));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next state and storage port drive for beat 1 (IDLE) and beat 2.
  // NOTE: every output gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    nxt       = state;
    arr_word  = '0;
    arr_en    = '0;
    arr_we    = '0;
    arr_wdata = '0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (err_in) begin
            nxt = RESP;
          end else begin
            arr_word  = word_in;
            arr_en    = {NB{1'b1}} >> off_in;
            arr_wdata = DATA_W'(rot_data(MAX_W'(req_wdata), NB, int'(off_in)));
            if (req_we) arr_we = arr_en & NB'(rot_mask(MAX_NB'(req_be), NB, int'(off_in)));
            nxt = (off_in == '0) ? RESP : BEAT2;
          end
        end
      end
      BEAT2: begin
        arr_word  = word_q + 1'b1;
        arr_en    = ~({NB{1'b1}} >> off_q);
        arr_wdata = DATA_W'(rot_data(MAX_W'(wdata_q), NB, int'(off_q)));
        if (we_q) arr_we = arr_en & NB'(rot_mask(MAX_NB'(be_q), NB, int'(off_q)));
        nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Capture the accepted request for beat 2 and the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (state == IDLE && req_valid) begin
      we_q    <= req_we;
      err_q   <= err_in;
      word_q  <= word_in;
      off_q   <= off_in;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  mem_byte_array #(
    .NB          (NB),
    .DEPTH_BYTES (DEPTH_BYTES),
    .WI_W        (WI_W),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .word  (arr_word),
    .en    (arr_en),
    .we    (arr_we),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Storage ports hold port-ordered bytes; rotate back to request lane order.
  assign rd_lanes  = DATA_W'(rot_data(MAX_W'(arr_rdata), NB, (NB - int'(off_q)) % NB));

  // Response is built only from flops, so it holds steady under backpressure.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? rd_lanes : '0;

endmodule

// File: tb/tb_mem_bytebus.sv
// Directed bench for mem_bytebus with DATA_W=16, DEPTH_BYTES=64.
module tb_mem_bytebus;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          lat;
    logic [15:0] rdata;
    logic [15:0] rmask;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  mem_bytebus #(
    .DATA_W      (16),
    .DEPTH_BYTES (64),
    .ADDR_W      (16),
    .INIT_FILE   ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be, input int lat, input logic [15:0] rdata,
                         input logic [15:0] rmask, input logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.lat = lat; v.rdata = rdata; v.rmask = rmask; v.err = err;
    vecs.push_back(v);
  endtask

  // Called #1 after a rising edge with the DUT idle. Returns the number of
  // edges from accept to rsp_valid and the response, then completes the
  // handshake and leaves the bench #1 after the following edge.
  task automatic transact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be, output int lat, output logic [15:0] rd,
                          output logic err, output logic drop_ok);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = rsp_rdata;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drop_ok = !rsp_valid && req_ready;
  endtask

  task automatic read_expect(input string name, input logic [15:0] addr,
                             input logic [15:0] exp);
    int lat; logic [15:0] rd; logic err; logic drop_ok;
    transact(1'b0, addr, 16'h0000, 2'b11, lat, rd, err, drop_ok);
    check({name, " rdata"}, 32'(rd), 32'(exp));
    check({name, " err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int lat; logic [15:0] rd; logic err; logic drop_ok;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;

    // Table: we, addr, wdata, be, latency, rdata, compare mask, err
    add_vec(1, 16'd4,      16'h1234, 2'b11, 1, 16'h0000, 16'hFFFF, 0);
    add_vec(0, 16'd4,      16'h0000, 2'b11, 1, 16'h1234, 16'hFFFF, 0);
    add_vec(1, 16'd4,      16'hABCD, 2'b01, 1, 16'h0000, 16'hFFFF, 0);
    add_vec(0, 16'd4,      16'h0000, 2'b11, 1, 16'h12CD, 16'hFFFF, 0);
    add_vec(1, 16'd5,      16'hBEEF, 2'b11, 2, 16'h0000, 16'hFFFF, 0);
    add_vec(0, 16'd4,      16'h0000, 2'b11, 1, 16'h12BE, 16'hFFFF, 0);
    add_vec(0, 16'd6,      16'h0000, 2'b11, 1, 16'hEF00, 16'hFF00, 0);
    add_vec(0, 16'd5,      16'h0000, 2'b11, 2, 16'hBEEF, 16'hFFFF, 0);
    add_vec(1, 16'd8,      16'h3344, 2'b11, 1, 16'h0000, 16'hFFFF, 0);
    add_vec(1, 16'd7,      16'h1122, 2'b10, 2, 16'h0000, 16'hFFFF, 0);
    add_vec(0, 16'd6,      16'h0000, 2'b11, 1, 16'hEF11, 16'hFFFF, 0);
    add_vec(0, 16'd8,      16'h0000, 2'b11, 1, 16'h3344, 16'hFFFF, 0);
    add_vec(1, 16'd9,      16'h9988, 2'b01, 2, 16'h0000, 16'hFFFF, 0);
    add_vec(0, 16'd9,      16'h0000, 2'b11, 2, 16'h4488, 16'hFFFF, 0);
    add_vec(0, 16'd4,      16'h0000, 2'b00, 1, 16'h12BE, 16'hFFFF, 0);
    add_vec(1, 16'd62,     16'h5A5A, 2'b11, 1, 16'h0000, 16'hFFFF, 0);
    add_vec(1, 16'd63,     16'hFFFF, 2'b11, 1, 16'h0000, 16'hFFFF, 1);
    add_vec(0, 16'd62,     16'h0000, 2'b11, 1, 16'h5A5A, 16'hFFFF, 0);
    add_vec(0, 16'hFFFF,   16'h0000, 2'b11, 1, 16'h0000, 16'hFFFF, 1);
    add_vec(1, 16'd12,     16'h6666, 2'b11, 1, 16'h0000, 16'hFFFF, 0);

    // Reset values.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", 32'(rsp_rdata), 32'h0);
    check("reset rsp_err",   32'(rsp_err),   32'd0);

    // Table-driven transactions.
    for (int i = 0; i < vecs.size(); i++) begin
      transact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, rd, err, drop_ok);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d rdata", i), 32'(rd & vecs[i].rmask), 32'(vecs[i].rdata & vecs[i].rmask));
      check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("v%0d drop after handshake", i), 32'(drop_ok), 32'd1);
    end

    // Backpressure: response held for 3 cycles while a competing write waits.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd4; req_wdata = '0; req_be = 2'b11;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_we = 1'b1; req_wdata = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("hold%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
      check($sformatf("hold%0d rsp_rdata", c), 32'(rsp_rdata), 32'h12BE);
      check($sformatf("hold%0d rsp_err", c),   32'(rsp_err),   32'd0);
      check($sformatf("hold%0d req_ready", c), 32'(req_ready), 32'd0);
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("hold release rsp_valid", 32'(rsp_valid), 32'd0);
    read_expect("no write under backpressure", 16'd4, 16'h12BE);

    // Reset during beat 2 of a misaligned write to bytes 11..12.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd11; req_wdata = 16'h7788; req_be = 2'b11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("beat2 req_ready", 32'(req_ready), 32'd0);
    check("beat2 rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async reset req_ready", 32'(req_ready), 32'd1);
    check("async reset rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_expect("beat1 byte written", 16'd10, 16'h8877);
    read_expect("beat2 byte untouched", 16'd12, 16'h6666);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
